// File: rtl/if_pkg.sv
// if_pkg: opcodes, opcode field bounds and sign-extended branch-offset helper shared by the fetch unit
package if_pkg;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 25;
    localparam int MAX_XLEN = 64;
    localparam logic [6:0] OP_B = 7'b1100000;
    localparam logic [6:0] OP_BR = 7'b1100010;
    function automatic logic [MAX_XLEN-1:0] br_offset(input logic [15:0] imm16);
        return {{(MAX_XLEN-18){imm16[15]}}, imm16, 2'b00};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous flushable FIFO; ports clk/rst, flush, push/din, pop/dout (0 when empty), count, full, empty
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input logic clk,
    input logic rst,
    input logic flush,
    input logic push,
    input logic [WIDTH-1:0] din,
    input logic pop,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0] count,
    output logic full,
    output logic empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = empty ? '0 : mem[rd];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            rd <= do_pop ? rd + 1'b1 : rd;
            wr <= do_push ? wr + 1'b1 : wr;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch stage with prefetch queue and B/BR resolution; ports clk/rst, imem_en/imem_addr/imem_rdata, br_addr/br_value, write_enable/write_addr/write_value, redirect_valid/redirect_pc, id_valid/id_ready/id_instr/id_pc, fetch_pc
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int NREG_W = 3
) (
    input logic clk,
    input logic rst,
    output logic imem_en,
    output logic [XLEN-1:0] imem_addr,
    input logic [31:0] imem_rdata,
    output logic [NREG_W-1:0] br_addr,
    input logic [XLEN-1:0] br_value,
    input logic write_enable,
    input logic [NREG_W-1:0] write_addr,
    input logic [XLEN-1:0] write_value,
    input logic redirect_valid,
    input logic [XLEN-1:0] redirect_pc,
    output logic id_valid,
    input logic id_ready,
    output logic [31:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] fetch_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [XLEN-1:0] fpc, inf_pc, off, base, tgt;
    logic [CW-1:0] count;
    logic [CW:0] pending;
    logic [6:0] opc;
    logic inf, inf_kill, resp, take, deq, full, empty;
    assign deq = id_valid && id_ready;
    assign pending = {1'b0, count} + (CW+1)'(inf) - (CW+1)'(deq);
    assign imem_en = !rst && !redirect_valid && (!full || deq) && pending < (CW+1)'(DEPTH);
    assign imem_addr = fpc;
    assign fetch_pc = fpc;
    assign resp = inf && !inf_kill;
    assign opc = imem_rdata[OPC_MSB:OPC_LSB];
    assign br_addr = inf ? imem_rdata[22 +: NREG_W] : '0;
    assign off = XLEN'(br_offset(imem_rdata[15:0]));
    assign base = (write_enable && write_addr == br_addr) ? write_value : br_value;
    assign tgt = (opc == OP_BR) ? (base + off) & ~XLEN'(3) : inf_pc + off;
    assign take = resp && (opc == OP_B || opc == OP_BR);
    assign id_valid = !empty;
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN + 32)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(redirect_valid),
        .push(resp && !redirect_valid),
        .din({inf_pc, imem_rdata}),
        .pop(deq),
        .dout({id_pc, id_instr}),
        .count(count),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc <= RESET_PC;
            inf <= 1'b0;
            inf_kill <= 1'b0;
            inf_pc <= '0;
        end else if (redirect_valid) begin
            fpc <= redirect_pc & ~XLEN'(3);
            inf <= 1'b0;
            inf_kill <= 1'b0;
        end else begin
            inf <= imem_en;
            inf_kill <= take;
            inf_pc <= imem_en ? fpc : inf_pc;
            fpc <= take ? tgt : imem_en ? fpc + XLEN'(4) : fpc;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and randomized checks of if_fetch_unit against an architectural program-walk model
module tb_if_fetch_unit;
    import if_pkg::*;
    logic clk = 0;
    logic rst = 1;
    logic imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [2:0] br_addr;
    logic [31:0] br_value;
    logic write_enable = 0;
    logic [2:0] write_addr = '0;
    logic [31:0] write_value = '0;
    logic redirect_valid = 0;
    logic [31:0] redirect_pc = '0;
    logic id_valid;
    logic id_ready = 0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] fetch_pc;
    logic [31:0] mem [1024];
    logic [31:0] regs [8];
    int tests = 0;
    int fails = 0;
    int delivered;
    logic [31:0] exp_pc;
    always #5 clk = ~clk;
    if_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .NREG_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .imem_en(imem_en),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .br_addr(br_addr),
        .br_value(br_value),
        .write_enable(write_enable),
        .write_addr(write_addr),
        .write_value(write_value),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_instr(id_instr),
        .id_pc(id_pc),
        .fetch_pc(fetch_pc)
    );
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr[11:2]];
    end
    assign br_value = regs[br_addr];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] enc_b(input logic [15:0] imm);
        return {OP_B, 9'd0, imm};
    endfunction
    function automatic logic [31:0] enc_br(input logic [2:0] r, input logic [15:0] imm);
        return {OP_BR, r, 6'd0, imm};
    endfunction
    function automatic logic [31:0] model_next(input logic [31:0] pc);
        logic [31:0] w;
        int off;
        w = mem[pc[11:2]];
        off = 4 * int'($signed(w[15:0]));
        if (w[31:25] == OP_B) return pc + off;
        if (w[31:25] == OP_BR) return (regs[w[24:22]] + off) & 32'hFFFF_FFFC;
        return pc + 4;
    endfunction
    task automatic fill_nops();
        for (int i = 0; i < 1024; i++) mem[i] = {7'h00, 25'(i)};
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        id_ready = 0;
        redirect_valid = 0;
        write_enable = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_imem_en", imem_en, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_br_addr", br_addr, 0);
        chk("rst_fetch_pc", fetch_pc, 0);
        rst = 0;
    endtask
    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 32'h0;
        regs[3] = 32'h100;
        fill_nops();
        do_reset();
        id_ready = 1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("seq_en", imem_en, 1);
            chk("seq_addr", imem_addr, 4 * c);
            chk("seq_valid", id_valid, c >= 2);
            if (c >= 2) chk("seq_pc", id_pc, 4 * (c - 2));
        end
        fill_nops();
        mem[4] = enc_b(16'hFFFC);
        do_reset();
        id_ready = 1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("b_no_0x14", id_valid && id_pc == 32'h14, 0);
            if (c == 6) begin
                chk("b_target_addr", imem_addr, 32'h0);
                chk("b_delivered_pc", id_pc, 32'h10);
                chk("b_delivered_instr", id_instr, enc_b(16'hFFFC));
            end
            if (c == 7) chk("b_bubble", id_valid, 0);
            if (c == 8) chk("b_target_pc", id_pc, 32'h0);
        end
        fill_nops();
        mem[0] = enc_br(3'd3, 16'd2);
        do_reset();
        id_ready = 1;
        @(negedge clk);
        write_enable = 1;
        write_addr = 3;
        write_value = 32'h200;
        #1;
        chk("br_addr", br_addr, 3);
        @(negedge clk);
        write_enable = 0;
        #1;
        chk("br_fwd_en", imem_en, 1);
        chk("br_fwd_addr", imem_addr, 32'h208);
        repeat (2) @(negedge clk);
        #1;
        chk("br_fwd_pc", id_pc, 32'h208);
        do_reset();
        id_ready = 1;
        @(negedge clk);
        write_enable = 1;
        write_addr = 2;
        write_value = 32'h200;
        #1;
        chk("br_addr2", br_addr, 3);
        @(negedge clk);
        write_enable = 0;
        #1;
        chk("br_nofwd_addr", imem_addr, 32'h108);
        fill_nops();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("stall_en", imem_en, c < 4);
        end
        chk("stall_valid", id_valid, 1);
        chk("stall_pc", id_pc, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            id_ready = 1;
            #1;
            chk("stall_rel_valid", id_valid, 1);
            chk("stall_rel_pc", id_pc, 4 * k);
        end
        do_reset();
        repeat (4) @(negedge clk);
        #1;
        chk("redir_pre_en", imem_en, 0);
        chk("redir_pre_pc", id_pc, 0);
        redirect_valid = 1;
        redirect_pc = 32'h402;
        @(negedge clk);
        redirect_valid = 0;
        id_ready = 1;
        #1;
        chk("redir_valid_low", id_valid, 0);
        chk("redir_en", imem_en, 1);
        chk("redir_addr", imem_addr, 32'h400);
        @(negedge clk);
        #1;
        chk("redir_valid_low2", id_valid, 0);
        @(negedge clk);
        #1;
        chk("redir_first_pc", id_pc, 32'h400);
        chk("redir_first_instr", id_instr, mem[256]);
        @(negedge clk);
        #1;
        chk("redir_second_pc", id_pc, 32'h404);
        mem[1] = enc_b(16'h0008);
        do_reset();
        id_ready = 1;
        repeat (2) @(negedge clk);
        redirect_valid = 1;
        redirect_pc = 32'h200;
        #1;
        chk("rdb_deq_valid", id_valid, 1);
        chk("rdb_deq_pc", id_pc, 0);
        chk("rdb_no_issue", imem_en, 0);
        @(negedge clk);
        redirect_valid = 0;
        #1;
        chk("rdb_flushed", id_valid, 0);
        chk("rdb_addr", imem_addr, 32'h200);
        repeat (2) @(negedge clk);
        #1;
        chk("rdb_first_pc", id_pc, 32'h200);
        @(negedge clk);
        #1;
        chk("rdb_second_pc", id_pc, 32'h204);
        for (int i = 0; i < 8; i++) regs[i] = 32'($urandom_range(0, 4095));
        for (int i = 0; i < 1024; i++) begin
            int r;
            logic [31:0] w;
            r = $urandom_range(0, 99);
            w = $urandom;
            if (w[31:25] == OP_B || w[31:25] == OP_BR) w[31] = 1'b0;
            if (r < 12) w = enc_b(16'($urandom_range(0, 64)) - 16'd32);
            else if (r < 24) w = enc_br(3'($urandom_range(0, 7)), 16'($urandom_range(0, 255)));
            mem[i] = w;
        end
        do_reset();
        exp_pc = 32'h0;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            id_ready = $urandom_range(0, 9) < 7;
            redirect_valid = $urandom_range(0, 49) == 0;
            redirect_pc = 32'($urandom_range(0, 32'hFFFF));
            #1;
            if (id_valid && id_ready) begin
                chk("rnd_pc", id_pc, exp_pc);
                chk("rnd_instr", id_instr, mem[exp_pc[11:2]]);
                exp_pc = model_next(exp_pc);
                delivered++;
            end
            if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        chk("rnd_progress", delivered > 500, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
